des_req_master: RTL

Host-side initiator for the DES core request/response interface. It accepts one command (data, key, mode, verify) on an upstream valid/ready port and issues it to the DES core. It then waits for the core's result and returns data plus status on a downstream valid/ready port. It also enforces a response timeout, so a hung or misbehaving core never stalls the host.

---
 rtl/des_pkg.sv | 17 +
 rtl/des_req_master.sv | 106 ++++++++++
 2 files changed

// File: rtl/des_pkg.sv
// Shared types and status encodings for the DES request master.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } des_req_state_e;

  typedef logic [63:0] des_block_t;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_CORE_ERR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT  = 2'b10;

endpackage

// File: rtl/des_req_master.sv
// Host-side initiator for the DES core: accepts one command, issues it, waits
// for the result (with timeout) and returns data plus status downstream.
module des_req_master
  import des_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       cmd_valid_in,
  output logic       cmd_ready_out,
  input  des_block_t cmd_data_in,
  input  des_block_t cmd_key_in,
  input  logic       cmd_mode_in,
  input  logic       cmd_verify_in,
  output logic       rsp_valid_out,
  input  logic       rsp_ready_in,
  output des_block_t rsp_data_out,
  output logic [1:0] rsp_status_out,
  output des_block_t des_data_out,
  output des_block_t des_key_out,
  output logic       des_mode_out,
  output logic       des_verify_out,
  output logic       des_in_valid_out,
  input  logic       des_ready_in,
  input  des_block_t des_result_in,
  input  logic       des_result_valid_in,
  input  logic       des_err_in,
  output logic       busy_out,
  output logic       stray_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  des_req_state_e   state;
  logic [CNT_W-1:0] wait_cnt;

  // Handshake outputs decode the state register only, so no input reaches an
  // output combinationally.
  assign cmd_ready_out    = (state == IDLE);
  assign des_in_valid_out = (state == ISSUE);
  assign rsp_valid_out    = (state == RESP);
  assign busy_out         = (state != IDLE);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      stray_out      <= 1'b0;
      des_data_out   <= '0;
      des_key_out    <= '0;
      des_mode_out   <= 1'b0;
      des_verify_out <= 1'b0;
      rsp_data_out   <= '0;
      rsp_status_out <= ST_OK;
    end else begin
      // Any result outside WAIT is dropped but remembered until reset.
      if (des_result_valid_in && (state != WAIT)) begin
        stray_out <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cmd_valid_in) begin
            des_data_out   <= cmd_data_in;
            des_key_out    <= cmd_key_in;
            des_mode_out   <= cmd_mode_in;
            des_verify_out <= cmd_verify_in;
            state          <= ISSUE;
          end
        end

        ISSUE: begin
          if (des_ready_in) begin
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end

        WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          // A result in the timeout cycle still takes priority.
          if (des_result_valid_in) begin
            rsp_data_out   <= des_result_in;
            rsp_status_out <= des_err_in ? ST_CORE_ERR : ST_OK;
            state          <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            rsp_data_out   <= '0;
            rsp_status_out <= ST_TIMEOUT;
            state          <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready_in) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
